// File: rtl/ram_req_ctrl_pkg.sv
// Shared types for the RAM request controller: FSM state encoding and the
// latched request record. The record widths match the controller defaults.
package ram_req_ctrl_pkg;

   localparam int REQ_WORD_W = 4;
   localparam int REQ_ADDR_W = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_ACK = 2'd2,
      RESP     = 2'd3
   } state_e;

   typedef struct packed {
      logic                  we;
      logic [REQ_ADDR_W-1:0] addr;
      logic [REQ_WORD_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/ram_req_ctrl_ack_timer.sv
// Ack watchdog: loaded with TIMEOUT when a strobe is issued, counts down
// while waiting for the RAM ack, saturates at zero. expired_o marks the
// last cycle in which an ack can still be accepted.
module ack_timer #(
   parameter int TIMEOUT = 8
) (
   input  logic clk_i,
   input  logic arstn_i,
   input  logic load_i,
   input  logic dec_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: load has priority, decrement never wraps below zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = CNT_W'(TIMEOUT);
      end else if (dec_i && (count_q != {CNT_W{1'b0}})) begin
         count_d = count_q - CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Counter register, cleared by reset.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   // A count of one means this wait cycle is the final one.
   assign expired_o = (count_q <= CNT_W'(1));

endmodule

// File: rtl/ram_req_ctrl.sv
// Single-outstanding request controller in front of the RAM: accepts a
// request, fires a one-cycle wr/rd strobe, waits for the matching ack (or
// a timeout) and returns a registered response.
module ram_req_ctrl
   import ram_req_ctrl_pkg::*;
#(
   parameter int WORD_WIDTH = REQ_WORD_W,
   parameter int ADDR_WIDTH = REQ_ADDR_W,
   parameter int TIMEOUT    = 8
) (
   input  logic                  clk_i,
   input  logic                  arstn_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [WORD_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_we_o,
   output logic [WORD_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  ram_wr_o,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
   output logic [WORD_WIDTH-1:0] ram_wr_data_o,
   input  logic                  ram_ack_wr_i,
   output logic                  ram_rd_o,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
   input  logic [WORD_WIDTH-1:0] ram_rd_data_i,
   input  logic                  ram_ack_rd_i
);

   state_e                state_q,     state_d;
   req_t                  req_q,       req_d;
   logic                  ready_q,     ready_d;
   logic                  wr_q,        wr_d;
   logic                  rd_q,        rd_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_we_q,    rsp_we_d;
   logic [WORD_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q,   rsp_err_d;

   logic timer_load_s;
   logic timer_dec_s;
   logic timer_expired_s;

   ack_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_ack_timer (
      .clk_i     (clk_i),
      .arstn_i   (arstn_i),
      .load_i    (timer_load_s),
      .dec_i     (timer_dec_s),
      .expired_o (timer_expired_s)
   );

   // Next-state, latched request, strobe and response computation.
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      wr_d         = 1'b0;
      rd_d         = 1'b0;
      rsp_we_d     = rsp_we_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      timer_load_s = 1'b0;
      timer_dec_s  = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid_i && ready_q) begin
               // Strobe flop is set now so it is high during ISSUE.
               req_d.we    = req_we_i;
               req_d.addr  = req_addr_i;
               req_d.wdata = req_wdata_i;
               wr_d        = req_we_i;
               rd_d        = ~req_we_i;
               state_d     = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            timer_load_s = 1'b1;
            state_d      = WAIT_ACK;
         end
         WAIT_ACK: begin
            timer_dec_s = 1'b1;
            // Matching ack is tested before expiry so a last-cycle ack wins.
            if (req_q.we && ram_ack_wr_i) begin
               rsp_we_d    = 1'b1;
               rsp_rdata_d = {WORD_WIDTH{1'b0}};
               rsp_err_d   = 1'b0;
               state_d     = RESP;
            end else if (!req_q.we && ram_ack_rd_i) begin
               rsp_we_d    = 1'b0;
               rsp_rdata_d = ram_rd_data_i;
               rsp_err_d   = 1'b0;
               state_d     = RESP;
            end else if (timer_expired_s) begin
               rsp_we_d    = req_q.we;
               rsp_rdata_d = {WORD_WIDTH{1'b0}};
               rsp_err_d   = 1'b1;
               state_d     = RESP;
            end else begin
               state_d = WAIT_ACK;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               rsp_we_d    = 1'b0;
               rsp_rdata_d = {WORD_WIDTH{1'b0}};
               rsp_err_d   = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d     = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   // State and output registers; ready comes out of reset already high.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q     <= IDLE;
         req_q       <= '{we: 1'b0, addr: {REQ_ADDR_W{1'b0}}, wdata: {REQ_WORD_W{1'b0}}};
         ready_q     <= 1'b1;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_rdata_q <= {WORD_WIDTH{1'b0}};
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         ready_q     <= ready_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready_o   = ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_we_o      = rsp_we_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_err_o     = rsp_err_q;
   assign ram_wr_o      = wr_q;
   assign ram_rd_o      = rd_q;
   assign ram_wr_addr_o = req_q.addr;
   assign ram_rd_addr_o = req_q.addr;
   assign ram_wr_data_o = req_q.wdata;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl. The reference is a transaction-level
// timestamp model: a request accepted in cycle T strobes in T+1, acks count
// in cycles T+2..T+1+TIMEOUT, and the response is valid from the cycle after
// completion until the response handshake.
module tb_ram_req_ctrl;

   localparam int WW = 4;
   localparam int AW = 4;
   localparam int TO = 8;

   logic          clk;
   logic          arstn_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_we_i;
   logic [AW-1:0] req_addr_i;
   logic [WW-1:0] req_wdata_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic          rsp_we_o;
   logic [WW-1:0] rsp_rdata_o;
   logic          rsp_err_o;
   logic          ram_wr_o;
   logic [AW-1:0] ram_wr_addr_o;
   logic [WW-1:0] ram_wr_data_o;
   logic          ram_ack_wr_i;
   logic          ram_rd_o;
   logic [AW-1:0] ram_rd_addr_o;
   logic [WW-1:0] ram_rd_data_i;
   logic          ram_ack_rd_i;

   ram_req_ctrl #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk_i         (clk),
      .arstn_i       (arstn_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_we_i      (req_we_i),
      .req_addr_i    (req_addr_i),
      .req_wdata_i   (req_wdata_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_we_o      (rsp_we_o),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_err_o     (rsp_err_o),
      .ram_wr_o      (ram_wr_o),
      .ram_wr_addr_o (ram_wr_addr_o),
      .ram_wr_data_o (ram_wr_data_o),
      .ram_ack_wr_i  (ram_ack_wr_i),
      .ram_rd_o      (ram_rd_o),
      .ram_rd_addr_o (ram_rd_addr_o),
      .ram_rd_data_i (ram_rd_data_i),
      .ram_ack_rd_i  (ram_ack_rd_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state
   int            tests = 0;
   int            fails = 0;
   int            k = 0;
   bit            busy = 1'b0;
   int            t_acc = -100;
   int            t_done = -1;
   bit            cur_we;
   logic [AW-1:0] cur_addr;
   logic [WW-1:0] cur_wdata;
   logic [WW-1:0] exp_rdata;
   bit            exp_err;
   logic [AW-1:0] last_addr = 4'h0;
   logic [WW-1:0] last_wdata = 4'h0;
   logic [WW-1:0] mem [16];

   // Stimulus policy: ack_mode 0=random 1=first window cycle 2=never 3=last window cycle
   int            ack_mode = 1;
   bit            spur_en = 1'b0;
   int            req_pct = 0;
   int            rdy_pct = 100;
   bit            dir_pending = 1'b0;
   bit            dir_we;
   logic [AW-1:0] dir_addr;
   logic [WW-1:0] dir_wdata;

   // Observations of the current transaction, used by literal pins
   bit            seen_rise;
   int            obs_rise = -1;
   logic [WW-1:0] obs_rdata;
   logic          obs_err;
   int            obs_valid_cycles = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
      end
   endtask

   // One clock cycle: check outputs mid-cycle, then drive this cycle's inputs.
   task automatic cycle();
      bit exp_valid;
      bit idle_now;
      bit end_txn;
      bit in_window;
      bit last_cycle;
      bit hit;
      bit spur;
      @(negedge clk);
      k++;
      exp_valid = busy && (t_done >= 0) && (k > t_done);
      chk("req_ready", req_ready_o, !busy);
      chk("ram_wr", ram_wr_o, busy && (k == t_acc + 1) && cur_we);
      chk("ram_rd", ram_rd_o, busy && (k == t_acc + 1) && !cur_we);
      chk("ram_wr_addr", ram_wr_addr_o, last_addr);
      chk("ram_rd_addr", ram_rd_addr_o, last_addr);
      chk("ram_wr_data", ram_wr_data_o, last_wdata);
      chk("rsp_valid", rsp_valid_o, exp_valid);
      if (exp_valid) begin
         chk("rsp_we", rsp_we_o, cur_we);
         chk("rsp_rdata", rsp_rdata_o, exp_rdata);
         chk("rsp_err", rsp_err_o, exp_err);
      end
      if (rsp_valid_o === 1'b1) begin
         obs_valid_cycles++;
         if (!seen_rise) begin
            seen_rise = 1'b1;
            obs_rise  = k;
            obs_rdata = rsp_rdata_o;
            obs_err   = rsp_err_o;
         end
      end

      idle_now    = !busy;
      rsp_ready_i = ($urandom_range(0, 99) < rdy_pct);
      end_txn     = exp_valid && rsp_ready_i;

      ram_ack_wr_i  = 1'b0;
      ram_ack_rd_i  = 1'b0;
      ram_rd_data_i = WW'($urandom_range(0, 15));
      in_window = busy && (t_done < 0) && (k >= t_acc + 2);
      if (in_window) begin
         last_cycle = (k == t_acc + 1 + TO);
         case (ack_mode)
            0:       hit = ($urandom_range(0, 3) == 0);
            1:       hit = 1'b1;
            3:       hit = last_cycle;
            default: hit = 1'b0;
         endcase
         spur = spur_en && ($urandom_range(0, 1) == 1);
         if (cur_we) begin
            ram_ack_wr_i = hit;
            ram_ack_rd_i = spur;
         end else begin
            ram_ack_rd_i = hit;
            ram_ack_wr_i = spur;
            if (hit) ram_rd_data_i = mem[cur_addr];
         end
         if (hit) begin
            t_done    = k;
            exp_err   = 1'b0;
            exp_rdata = cur_we ? 4'h0 : mem[cur_addr];
            if (cur_we) mem[cur_addr] = cur_wdata;
         end else if (last_cycle) begin
            t_done    = k;
            exp_err   = 1'b1;
            exp_rdata = 4'h0;
         end
      end else if (spur_en) begin
         ram_ack_wr_i = ($urandom_range(0, 2) == 0);
         ram_ack_rd_i = ($urandom_range(0, 2) == 0);
      end

      req_we_i    = $urandom_range(0, 1);
      req_addr_i  = AW'($urandom_range(0, 15));
      req_wdata_i = WW'($urandom_range(0, 15));
      if (idle_now) begin
         if (dir_pending || ($urandom_range(0, 99) < req_pct)) begin
            if (dir_pending) begin
               req_we_i    = dir_we;
               req_addr_i  = dir_addr;
               req_wdata_i = dir_wdata;
               dir_pending = 1'b0;
            end
            req_valid_i      = 1'b1;
            busy             = 1'b1;
            t_acc            = k;
            t_done           = -1;
            cur_we           = req_we_i;
            cur_addr         = req_addr_i;
            cur_wdata        = req_wdata_i;
            last_addr        = req_addr_i;
            last_wdata       = req_wdata_i;
            seen_rise        = 1'b0;
            obs_rise         = -1;
            obs_valid_cycles = 0;
         end else begin
            req_valid_i = 1'b0;
         end
      end else begin
         req_valid_i = $urandom_range(0, 1);
      end
      if (end_txn) busy = 1'b0;
   endtask

   task automatic issue(bit we, logic [AW-1:0] a, logic [WW-1:0] d);
      dir_pending = 1'b1;
      dir_we      = we;
      dir_addr    = a;
      dir_wdata   = d;
      cycle();
   endtask

   task automatic run_until_idle(int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         cycle();
         n++;
      end
      chk("idle_within_budget", busy, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      k++;
      arstn_i = 1'b0;
      #1;
      chk("rst_ram_wr", ram_wr_o, 1'b0);
      chk("rst_ram_rd", ram_rd_o, 1'b0);
      chk("rst_rsp_valid", rsp_valid_o, 1'b0);
      chk("rst_req_ready", req_ready_o, 1'b1);
      ram_ack_wr_i = 1'b1;
      ram_ack_rd_i = 1'b1;
      req_valid_i  = 1'b0;
      busy       = 1'b0;
      t_done     = -1;
      last_addr  = 4'h0;
      last_wdata = 4'h0;
      repeat (2) begin
         @(negedge clk);
         k++;
      end
      arstn_i = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 4'h0;
      arstn_i       = 1'b0;
      req_valid_i   = 1'b0;
      req_we_i      = 1'b0;
      req_addr_i    = 4'h0;
      req_wdata_i   = 4'h0;
      rsp_ready_i   = 1'b0;
      ram_ack_wr_i  = 1'b0;
      ram_ack_rd_i  = 1'b0;
      ram_rd_data_i = 4'h0;
      repeat (2) @(negedge clk);
      chk("reset_ready", req_ready_o, 1'b1);
      chk("reset_valid", rsp_valid_o, 1'b0);
      chk("reset_strobes", {ram_wr_o, ram_rd_o}, 2'b00);
      chk("reset_rsp", {rsp_we_o, rsp_err_o, rsp_rdata_o}, 6'h00);
      arstn_i = 1'b1;

      // Write then read back
      ack_mode = 1; rdy_pct = 100; spur_en = 1'b0; req_pct = 0;
      issue(1'b1, 4'h3, 4'hA);
      run_until_idle(50);
      chk("wr_rsp_latency", obs_rise - t_acc, 3);
      chk("wr_rsp_err", obs_err, 1'b0);
      issue(1'b0, 4'h3, 4'h0);
      run_until_idle(50);
      chk("rd_rsp_latency", obs_rise - t_acc, 3);
      chk("rd_rsp_rdata", obs_rdata, 4'hA);
      chk("rd_rsp_err", obs_err, 1'b0);

      // Response backpressure for 5 cycles
      rdy_pct = 0;
      issue(1'b0, 4'h3, 4'h0);
      repeat (7) cycle();
      rdy_pct = 100;
      run_until_idle(50);
      chk("bp_valid_cycles", obs_valid_cycles, 6);
      chk("bp_rdata", obs_rdata, 4'hA);

      // Timeout, then a clean write
      ack_mode = 2;
      issue(1'b0, 4'h5, 4'h0);
      run_until_idle(50);
      chk("to_latency", obs_rise - t_acc, TO + 2);
      chk("to_err", obs_err, 1'b1);
      chk("to_rdata", obs_rdata, 4'h0);
      ack_mode = 1;
      issue(1'b1, 4'h5, 4'h7);
      run_until_idle(50);
      chk("after_to_err", obs_err, 1'b0);

      // Ack in the final wait cycle, with spurious write acks during the read
      ack_mode = 3; spur_en = 1'b1;
      issue(1'b0, 4'h5, 4'h0);
      run_until_idle(50);
      chk("edge_latency", obs_rise - t_acc, TO + 2);
      chk("edge_err", obs_err, 1'b0);
      chk("edge_rdata", obs_rdata, 4'h7);

      // Reset in the middle of WAIT_ACK; stale acks afterwards are ignored
      ack_mode = 2; spur_en = 1'b0;
      issue(1'b0, 4'h5, 4'h0);
      repeat (3) cycle();
      do_reset();
      spur_en = 1'b1;
      repeat (12) cycle();
      chk("no_rsp_after_reset", obs_valid_cycles, 0);

      // Randomized traffic
      ack_mode = 0; req_pct = 50; rdy_pct = 60;
      repeat (2000) cycle();
      req_pct = 0; rdy_pct = 100;
      run_until_idle(200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
Request-side controller that sits directly upstream of the single-port-per-direction RAM and drives its write/read strobes. It accepts one word request at a time over a valid/ready channel from the bus master, issues a one-cycle wr/rd strobe to the RAM, and waits for the matching ack. It returns a valid/ready response carrying read data, or an error if no ack arrives within a bounded window. Only one request is outstanding at a time.

Parameters:
WORD_WIDTH, 4, data word width; must equal the RAM's WORD_WIDTH.
ADDR_WIDTH, 4, address width; must equal the RAM's ADDR_WIDTH.
TIMEOUT, 8, maximum cycles spent in WAIT_ACK before an error response; must be >= 1.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
arstn_i  in  1  reset, asynchronous, active-low.
req_valid_i  in  1  master request valid.
req_ready_o  out  1  controller can accept a request.
req_we_i  in  1  1 = write, 0 = read.
req_addr_i  in  ADDR_WIDTH  request address.
req_wdata_i  in  WORD_WIDTH  write data; ignored for reads.
rsp_valid_o  out  1  response valid.
rsp_ready_i  in  1  master accepts the response.
rsp_we_o  out  1  echo of the request's req_we_i.
rsp_rdata_o  out  WORD_WIDTH  read data; 0 for writes and errors.
rsp_err_o  out  1  1 = ack timeout.
ram_wr_o  out  1  RAM write strobe, to the RAM's wr_i.
ram_wr_addr_o  out  ADDR_WIDTH  to the RAM's wr_ADDR_i.
ram_wr_data_o  out  WORD_WIDTH  to the RAM's wr_data_i.
ram_ack_wr_i  in  1  from the RAM's ack_wr_o.
ram_rd_o  out  1  RAM read strobe, to the RAM's rd_i.
ram_rd_addr_o  out  ADDR_WIDTH  to the RAM's rd_ADDR_i.
ram_rd_data_i  in  WORD_WIDTH  from the RAM's rd_data_o.
ram_ack_rd_i  in  1  from the RAM's ack_rd_o.

Behaviour:
- Reset (arstn_i low, asynchronous): FSM goes to IDLE; all outputs 0 except req_ready_o, which is 1 once in IDLE. Latched request registers and the timer are cleared.
- A reset mid-operation abandons the transaction; no response is produced.
- FSM states: IDLE, ISSUE, WAIT_ACK, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o, latch we/addr/wdata and go to ISSUE.
- ISSUE (exactly one cycle):
  - Assert ram_wr_o if the latched we = 1, else ram_rd_o.
  - Load the timer with TIMEOUT; go to WAIT_ACK.
- Strobes:
  - Strobes are registered and high for exactly one cycle per request.
  - ram_*_addr_o and ram_wr_data_o come from the latched registers and stay stable from ISSUE until the next accepted request.
- WAIT_ACK:
  - A write completes on ram_ack_wr_i; a read completes on ram_ack_rd_i.
  - On a read ack, capture ram_rd_data_i in that same cycle.
  - On the matching ack, set err = 0 and go to RESP.
  - A non-matching ack is ignored.
  - The timer decrements each cycle. If it reaches 0 with no matching ack, go to RESP with err = 1 and rdata = 0.
  - If the ack arrives in the same cycle the timer expires, the ack wins.
- Acks seen outside WAIT_ACK are ignored. This covers stale acks after reset, since the RAM's ack is not reset.
- RESP:
  - rsp_valid_o = 1; rsp_we_o, rsp_rdata_o and rsp_err_o are registered and stable while valid.
  - Stay in RESP until rsp_ready_i, then go to IDLE.
  - rsp_valid_o drops the cycle after the handshake.
  - req_ready_o = 0 in every state except IDLE.
- Latency, with the request handshake at cycle T:
  - Strobe at T+1.
  - RAM ack at T+2.
  - rsp_valid_o at T+3 with rsp_ready_i held high.
  - Back-to-back throughput is one request per 4 cycles.
- Timeout: rsp_valid_o rises TIMEOUT+2 cycles after the handshake.
- The timer is $clog2(TIMEOUT+1) bits wide and never wraps; it saturates at 0.

Decomposition:
- Package ram_req_ctrl_pkg holds the state_e enum (IDLE, ISSUE, WAIT_ACK, RESP) and a req_t packed struct {we, addr, wdata}. The struct is parameterised via localparams matching the defaults; widths come from the module parameters.
- One sub-module, ack_timer: load, decrement and expired flag, parameterised by TIMEOUT.

Test Plan:
- Write then read: write addr 3 data 0xA, then read addr 3 -> ram_wr_o pulses 1 cycle at T+1; write response at T+3 with err = 0; read response rdata = 0xA, err = 0.
- Response backpressure: read with rsp_ready_i held low 5 cycles -> rsp_valid_o and rdata stable for 5 cycles, req_ready_o = 0 throughout; returns to IDLE one cycle after ready.
- Timeout: tie acks low, TIMEOUT = 8, issue a read -> rsp_err_o = 1, rdata = 0, rsp_valid_o at T+10; a later normal request completes cleanly.
- Ack at the expiry edge: force ram_ack_rd_i in the last WAIT_ACK cycle -> err = 0, data captured.
- Spurious ack: pulse ram_ack_wr_i during a read and in IDLE -> ignored; read completes only on ram_ack_rd_i.
- Reset mid-WAIT_ACK: drop arstn_i -> strobes and rsp_valid_o low immediately; no response after release; req_ready_o = 1 in the first cycle after reset.
